map_manager: RTL

// - Owns the live 20x20 tile map consumed by playerManager (inMapData) and the tile renderer.
// - Loads each level from an external synchronous map ROM with a tile-copy FSM.
// - Clears enemy tiles on kill requests (enemyOverlap/currRow/currCol).
// - Advances to the next level on a ladder request (collisionTile==7) and pulses player_reload so the player respawns at tile 31.
//

---
 rtl/map_manager_if.sv | 10 +
 rtl/map_manager.sv | 136 +++++++++++++
 2 files changed

// File: rtl/map_manager_if.sv
// ROM read port of the map manager: registered address out, tile data back one Clk later.
interface map_manager_if #(
  parameter int ROM_AW = 11
);
  logic [ROM_AW-1:0] rom_addr;
  logic [4:0]        rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/map_manager.sv
// Live 20x20 tile map: level load from ROM, enemy tile kills, ladder level advance.
// Define MAP_WRAP_EN to wrap from the final level back to level 0 instead of winning.
module map_manager #(
  parameter int NUM_MAPS = 4,
  parameter int ROM_AW   = 11
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic [4:0]        collisionTile,
  input  logic              enemyOverlap,
  input  logic [4:0]        currRow,
  input  logic [4:0]        currCol,
  map_manager_if.master     rom,
  output logic [4:0]        mapData [0:399],
  output logic [1:0]        mapIndex,
  output logic              map_ready,
  output logic              player_reload,
  output logic              game_won
);

  typedef enum logic [1:0] {LOAD, RELOAD, RUN, WON} state_t;

  state_t            state, state_next;
  logic [8:0]        cnt;
  logic              armed;
  logic              ladder_req, ladder_fire, final_level, in_range, killable;
  logic              load_level, go_won, kill_en;
  logic [8:0]        kill_idx, kill_idx_safe;
  logic [1:0]        next_index;
  logic [ROM_AW-1:0] next_base;

  assign ladder_req    = (collisionTile == 5'd7);
  assign ladder_fire   = frame_tick && ladder_req && armed;
  assign final_level   = (int'(mapIndex) == NUM_MAPS - 1);
  assign in_range      = (currRow < 5'd20) && (currCol < 5'd20);
  assign kill_idx      = 9'(currRow) * 9'd20 + 9'(currCol);
  assign kill_idx_safe = in_range ? kill_idx : 9'd0;

`ifdef MAP_WRAP_EN
  assign next_index = final_level ? 2'd0 : mapIndex + 2'd1;
`else
  assign next_index = mapIndex + 2'd1;
`endif
  assign next_base = ROM_AW'(int'(next_index) * 400);

  always_comb begin
    killable = 1'b0;
    case (mapData[kill_idx_safe])
      5'd3, 5'd4, 5'd10, 5'd11, 5'd12, 5'd13: killable = 1'b1;
      default: killable = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) state <= LOAD;
    else        state <= state_next;
  end

  // A ladder on the same tick as a kill wins: the map is about to be replaced anyway.
  always_comb begin
    state_next = state;
    load_level = 1'b0;
    go_won     = 1'b0;
    kill_en    = 1'b0;
    case (state)
      LOAD:    if (cnt == 9'd400) state_next = RELOAD;
      RELOAD:  state_next = RUN;
      RUN: begin
        if (frame_tick) begin
          if (ladder_fire) begin
`ifdef MAP_WRAP_EN
            state_next = LOAD;
            load_level = 1'b1;
`else
            if (final_level) begin
              state_next = WON;
              go_won     = 1'b1;
            end else begin
              state_next = LOAD;
              load_level = 1'b1;
            end
`endif
          end else if (enemyOverlap && in_range && killable) begin
            kill_en = 1'b1;
          end
        end
      end
      default: state_next = state;
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 400; i++) mapData[i] <= '0;
      mapIndex      <= 2'd0;
      rom.rom_addr  <= '0;
      map_ready     <= 1'b0;
      player_reload <= 1'b0;
      game_won      <= 1'b0;
      cnt           <= 9'd0;
      armed         <= 1'b0;
    end else begin
      player_reload <= 1'b0;
      case (state)
        LOAD: begin
          armed <= 1'b0;
          if (cnt != 9'd0) mapData[cnt - 9'd1] <= rom.rom_data;
          if (cnt != 9'd400) cnt <= cnt + 9'd1;
          else               player_reload <= 1'b1;
          if (cnt < 9'd399) rom.rom_addr <= rom.rom_addr + ROM_AW'(1);
        end
        RELOAD: begin
          armed     <= 1'b0;
          map_ready <= 1'b1;
        end
        RUN: begin
          if (frame_tick) begin
            // Arm only after a frame without the key, so a held key fires once.
            armed <= !ladder_req;
            if (load_level) begin
              mapIndex     <= next_index;
              rom.rom_addr <= next_base;
              cnt          <= 9'd0;
              map_ready    <= 1'b0;
            end
            if (go_won) game_won <= 1'b1;
            if (kill_en) mapData[kill_idx_safe] <= 5'd0;
          end
        end
        default: map_ready <= 1'b1;
      endcase
    end
  end

endmodule
